pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It steps the game through idle, serve countdown, rally, point pause and game over, and keeps both players' scores. It issues the round-reset pulse that recentres the paddles and ball, the serve direction, and the per-side AI/keyboard select for the two paddle instances. It sits between the top level (buttons, switches, frame tick) and the paddle and ball blocks.

---
 rtl/pong_match_ctrl_if.sv | 37 +++
 rtl/pong_match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// ============================================================================
// pong_match_ctrl_if : game-side controls in, match status out
// Revision 1.0
// ============================================================================
`default_nettype none

interface pong_match_ctrl_if;
   logic       frame_tick;
   logic       start;
   logic       miss_left;
   logic       miss_right;
   logic [1:0] ai_mode;
   logic       ai_ctrl_left;
   logic       ai_ctrl_right;
   logic       round_reset;
   logic       run;
   logic       serve_dir;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic [2:0] state;
   logic       game_over;
   logic       winner;

   modport master (
      output frame_tick, start, miss_left, miss_right, ai_mode,
      input  ai_ctrl_left, ai_ctrl_right, round_reset, run, serve_dir,
             score_left, score_right, state, game_over, winner
   );

   modport slave (
      input  frame_tick, start, miss_left, miss_right, ai_mode,
      output ai_ctrl_left, ai_ctrl_right, round_reset, run, serve_dir,
             score_left, score_right, state, game_over, winner
   );
endinterface

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ============================================================================
// pong_match_ctrl : pong match sequencer (serve, rally, point pause, scoring)
// Revision 1.0
// ============================================================================
`default_nettype none

module pong_match_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic             clk,
   input  logic             reset,
   pong_match_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);

   state_t     state_q, state_n;
   logic [7:0] cnt_q, cnt_n;
   logic       start_d;
   logic [3:0] score_l_q, score_l_n, score_r_q, score_r_n;
   logic       serve_dir_q, serve_dir_n;
   logic       ai_l_q, ai_l_n, ai_r_q, ai_r_n;
   logic       winner_q, winner_n;
   logic       round_reset_q, round_reset_n;
   logic       run_q, game_over_q;
   logic       start_rise;
   logic [3:0] score_l_inc, score_r_inc;

   assign start_rise  = bus.start & ~start_d;
   assign score_l_inc = score_l_q + 4'd1;
   assign score_r_inc = score_r_q + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         start_d       <= 1'b0;
         score_l_q     <= 4'd0;
         score_r_q     <= 4'd0;
         serve_dir_q   <= 1'b1;
         ai_l_q        <= 1'b0;
         ai_r_q        <= 1'b0;
         winner_q      <= 1'b0;
         round_reset_q <= 1'b0;
         run_q         <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_n;
         cnt_q         <= cnt_n;
         start_d       <= bus.start;
         score_l_q     <= score_l_n;
         score_r_q     <= score_r_n;
         serve_dir_q   <= serve_dir_n;
         ai_l_q        <= ai_l_n;
         ai_r_q        <= ai_r_n;
         winner_q      <= winner_n;
         round_reset_q <= round_reset_n;
         // Status flags follow the next state so they change on the same edge.
         run_q         <= (state_n == PLAY);
         game_over_q   <= (state_n == OVER);
      end
   end

   always_comb begin
      state_n       = state_q;
      cnt_n         = cnt_q;
      score_l_n     = score_l_q;
      score_r_n     = score_r_q;
      serve_dir_n   = serve_dir_q;
      ai_l_n        = ai_l_q;
      ai_r_n        = ai_r_q;
      winner_n      = winner_q;
      round_reset_n = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (start_rise) begin
               state_n       = SERVE;
               cnt_n         = 8'd0;
               score_l_n     = 4'd0;
               score_r_n     = 4'd0;
               serve_dir_n   = 1'b1;
               ai_l_n        = bus.ai_mode[1];
               ai_r_n        = bus.ai_mode[0];
               round_reset_n = 1'b1;
            end
         end
         SERVE: begin
            if (bus.frame_tick) begin
               if (cnt_q == SERVE_LAST) begin
                  state_n = PLAY;
                  cnt_n   = 8'd0;
               end else begin
                  cnt_n = cnt_q + 8'd1;
               end
            end
         end
         PLAY: begin
            // A simultaneous miss_right is dropped in favour of miss_left.
            if (bus.miss_left) begin
               score_r_n   = score_r_inc;
               serve_dir_n = 1'b0;
               cnt_n       = 8'd0;
               if (score_r_inc == WIN) begin
                  state_n  = OVER;
                  winner_n = 1'b0;
               end else begin
                  state_n = POINT;
               end
            end else if (bus.miss_right) begin
               score_l_n   = score_l_inc;
               serve_dir_n = 1'b1;
               cnt_n       = 8'd0;
               if (score_l_inc == WIN) begin
                  state_n  = OVER;
                  winner_n = 1'b1;
               end else begin
                  state_n = POINT;
               end
            end
         end
         POINT: begin
            if (bus.frame_tick) begin
               if (cnt_q == POINT_LAST) begin
                  state_n       = SERVE;
                  cnt_n         = 8'd0;
                  round_reset_n = 1'b1;
               end else begin
                  cnt_n = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

   assign bus.state         = state_q;
   assign bus.round_reset   = round_reset_q;
   assign bus.run           = run_q;
   assign bus.serve_dir     = serve_dir_q;
   assign bus.score_left    = score_l_q;
   assign bus.score_right   = score_r_q;
   assign bus.game_over     = game_over_q;
   assign bus.winner        = winner_q;
   assign bus.ai_ctrl_left  = ai_l_q;
   assign bus.ai_ctrl_right = ai_r_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
// tb_pong_match_ctrl : vector-table bench for the pong match sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pong_match_ctrl_if bus ();

   pong_match_ctrl #(
      .WIN_SCORE    (3),
      .SERVE_FRAMES (4),
      .POINT_FRAMES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // exp = {state, round_reset, run, serve_dir, score_left, score_right, game_over, winner, ai_l, ai_r}
   typedef struct packed {
      logic        ft;
      logic        st;
      logic        ml;
      logic        mr;
      logic [1:0]  ai;
      logic [17:0] exp;
   } vec_t;

   vec_t vq[$];
   vec_t vq2[$];

   function automatic vec_t mk(bit ft, bit st, bit ml, bit mr, logic [1:0] ai,
                               logic [2:0] s, bit rr, bit run, bit sd,
                               logic [3:0] sl, logic [3:0] sr, bit go, bit w,
                               bit al, bit ar);
      vec_t v;
      v.ft  = ft;
      v.st  = st;
      v.ml  = ml;
      v.mr  = mr;
      v.ai  = ai;
      v.exp = {s, rr, run, sd, sl, sr, go, w, al, ar};
      return v;
   endfunction

   function automatic logic [17:0] actual();
      return {bus.state, bus.round_reset, bus.run, bus.serve_dir, bus.score_left,
              bus.score_right, bus.game_over, bus.winner, bus.ai_ctrl_left,
              bus.ai_ctrl_right};
   endfunction

   task automatic check(string name, logic [17:0] exp);
      logic [17:0] act;
      act   = actual();
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %05h required %05h", name, act, exp);
      end
   endtask

   task automatic apply(vec_t v, string tag, int idx);
      bus.frame_tick = v.ft;
      bus.start      = v.st;
      bus.miss_left  = v.ml;
      bus.miss_right = v.mr;
      bus.ai_mode    = v.ai;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, idx), v.exp);
   endtask

   initial begin
      //            ft st ml mr ai     s  rr run sd sl sr go w al ar
      vq.push_back(mk(1, 1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0)); // start; tick ignored
      vq.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 2, 0, 1, 1, 0, 0, 0, 0, 1, 0)); // 4th tick -> PLAY
      vq.push_back(mk(0, 0, 0, 1, 2'b10, 3, 0, 0, 1, 1, 0, 0, 0, 1, 0)); // left scores
      vq.push_back(mk(1, 0, 0, 1, 2'b10, 3, 0, 0, 1, 1, 0, 0, 0, 1, 0)); // miss in POINT ignored
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 1, 0, 0, 2'b10, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0)); // start in SERVE ignored
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 2, 0, 1, 1, 1, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 1, 1, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0, 1, 0)); // simultaneous misses
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 2, 0, 1, 0, 1, 1, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 1, 0, 2'b10, 3, 0, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 3, 0, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 2, 0, 1, 0, 1, 2, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 1, 0, 2'b10, 4, 0, 0, 0, 1, 3, 1, 0, 1, 0)); // right wins
      vq.push_back(mk(1, 0, 1, 1, 2'b10, 4, 0, 0, 0, 1, 3, 1, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 4, 0, 0, 0, 1, 3, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 2'b01, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1)); // restart from OVER
      vq.push_back(mk(0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1)); // held start
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1)); // ai change ignored
      vq.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1)); // counter now 2

      vq2.push_back(mk(1, 0, 1, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // IDLE ignores these
      vq2.push_back(mk(0, 1, 0, 0, 2'b11, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1));

      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      bus.ai_mode    = 2'b00;
      reset          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;

      foreach (vq[i]) apply(vq[i], "match", i);

      // Asynchronous reset mid-SERVE: takes effect without a clock edge.
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_reset", {3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1 reset = 1'b0;
      check("reset_hold", {3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});

      foreach (vq2[i]) apply(vq2[i], "idle", i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
